// File: rtl/ptb_window_capture.sv
// Pretrigger circular buffer with trigger-driven window readout (valid/first/last framing).
// Define PTB_RETRIGGER_EN to let a mid-window trigger extend the window instead of being dropped.
`timescale 1ns/1ps
module ptb_window_capture #(
  parameter int P_DATA_WIDTH = 28,
  parameter int P_ADDR_WIDTH = 6,
  parameter int P_POST_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [P_DATA_WIDTH-1:0] stream_in,
  input  logic                    trig_in,
  input  logic [P_ADDR_WIDTH-1:0] pre_config,
  input  logic [P_POST_WIDTH-1:0] post_config,
  output logic                    rdy,
  output logic                    busy,
  output logic [P_DATA_WIDTH-1:0] out_data,
  output logic                    out_valid,
  output logic                    out_first,
  output logic                    out_last,
  output logic [15:0]             trig_drop_cnt
);

  localparam int DEPTH = 2 ** P_ADDR_WIDTH;
  localparam int RW    = P_ADDR_WIDTH + P_POST_WIDTH + 1;
  localparam logic [P_ADDR_WIDTH-1:0] PRE_MAX = P_ADDR_WIDTH'(DEPTH - 2);

  typedef enum logic [1:0] {S_FILL, S_IDLE, S_READOUT} state_t;

  logic [P_DATA_WIDTH-1:0] mem [DEPTH];
  logic [P_DATA_WIDTH-1:0] rd_data_reg;
  logic [P_ADDR_WIDTH-1:0] wr_addr_reg, rd_addr, eff_pre_reg, eff_pre_next, pre_clip;
  logic                    rdy_reg, first_reg, first_next;
  logic [RW-1:0]           rem_reg, rem_next, win_len;
  logic [15:0]             drop_reg, drop_next;
  state_t                  state_reg, state_next;

  always_comb begin
    pre_clip = pre_config;
    if (pre_config == '0)
      pre_clip = P_ADDR_WIDTH'(1);
    else if (pre_config > PRE_MAX)
      pre_clip = PRE_MAX;
  end

  // Read pointer trails the write pointer so s_j reaches out_data at j+eff_pre+1.
  assign rd_addr = wr_addr_reg - eff_pre_reg;
  assign win_len = RW'(eff_pre_reg) + RW'(post_config);

  always_ff @(posedge clk) begin
    mem[wr_addr_reg] <= stream_in;
    rd_data_reg      <= mem[rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr_reg <= '0;
      rdy_reg     <= 1'b0;
    end else begin
      wr_addr_reg <= wr_addr_reg + 1'b1;
      if (wr_addr_reg == P_ADDR_WIDTH'(DEPTH - 1))
        rdy_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_FILL;
      rem_reg     <= '0;
      first_reg   <= 1'b0;
      drop_reg    <= '0;
      eff_pre_reg <= P_ADDR_WIDTH'(1);
    end else begin
      state_reg   <= state_next;
      rem_reg     <= rem_next;
      first_reg   <= first_next;
      drop_reg    <= drop_next;
      eff_pre_reg <= eff_pre_next;
    end
  end

  // rem_reg holds the number of samples still to come after the one on out_data.
  always_comb begin
    state_next   = state_reg;
    rem_next     = rem_reg;
    first_next   = 1'b0;
    drop_next    = drop_reg;
    eff_pre_next = eff_pre_reg;
    case (state_reg)
      S_FILL: begin
        if (rdy_reg)
          state_next = S_IDLE;
      end
      S_IDLE: begin
        if (trig_in) begin
          state_next = S_READOUT;
          rem_next   = win_len;
          first_next = 1'b1;
        end
      end
      S_READOUT: begin
        if (rem_reg == '0) begin
          if (trig_in) begin
            rem_next   = win_len;
            first_next = 1'b1;
          end else begin
            state_next = S_IDLE;
          end
        end else begin
          rem_next = rem_reg - 1'b1;
`ifdef PTB_RETRIGGER_EN
          if (trig_in)
            rem_next = win_len;
`else
          if (trig_in && drop_reg != 16'hFFFF)
            drop_next = drop_reg + 1'b1;
`endif
        end
      end
      default: state_next = S_FILL;
    endcase
    if (state_next != S_READOUT)
      eff_pre_next = pre_clip;
  end

  assign rdy           = rdy_reg;
  assign busy          = (state_reg == S_READOUT);
  assign out_valid     = busy;
  assign out_first     = busy & first_reg;
  assign out_last      = busy & (rem_reg == '0);
  assign out_data      = busy ? rd_data_reg : '0;
  assign trig_drop_cnt = drop_reg;

endmodule

// File: tb/tb_ptb_window_capture.sv
// Scoreboard bench for ptb_window_capture: directed triggers on a ramp input, monitor checks framed windows.
`timescale 1ns/1ps
module tb_ptb_window_capture;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [27:0] stream_in = '0;
  logic        trig_in = 1'b0;
  logic [5:0]  pre_config = 6'd4;
  logic [7:0]  post_config = 8'd3;
  logic        rdy, busy, out_valid, out_first, out_last;
  logic [27:0] out_data;
  logic [15:0] trig_drop_cnt;

  typedef struct {int cyc; int data; bit first; bit last;} exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int   cyc;
  int   n_checks = 0;
  int   n_fail = 0;

  ptb_window_capture dut (
    .clk(clk), .rst_n(rst_n), .stream_in(stream_in), .trig_in(trig_in),
    .pre_config(pre_config), .post_config(post_config), .rdy(rdy), .busy(busy),
    .out_data(out_data), .out_valid(out_valid), .out_first(out_first),
    .out_last(out_last), .trig_drop_cnt(trig_drop_cnt)
  );

  always #5 clk = ~clk;

  // cyc is the index of the cycle whose inputs are being presented / outputs shown.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic push_window(input int start, input int d0, input int len, input bit aborted);
    for (int i = 0; i < len; i++) begin
      exp_t e;
      e.cyc = start + i; e.data = d0 + i;
      e.first = (i == 0); e.last = (i == len - 1) && !aborted;
      sb.push_back(e);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; trig_in = 1'b0; stream_in = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_rdy", rdy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_drop", trig_drop_cnt, 0);
    rst_n = 1'b1;
  endtask

  task automatic run_test(input string name, input int k1, input int k2, input int pre, input int post,
                          input int last_cyc, input int rst_at,
                          input int w1s, input int w1d, input int w1l,
                          input int w2s, input int w2d, input int w2l,
                          input int busy_low, input int exp_drop);
    $display("test %s", name);
    do_reset();
    forever begin
      if (cyc == rst_at) begin
        rst_n = 1'b0; trig_in = 1'b0;
        #1;
        chk("abort_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_data", out_data, 0);
        chk("abort_flags", {out_first, out_last}, 0);
        chk("abort_rdy", rdy, 0);
        chk("abort_drop", trig_drop_cnt, 0);
        break;
      end
      stream_in   = 28'(cyc);
      pre_config  = 6'(pre);
      post_config = 8'(post);
      trig_in     = (cyc == 10) || (cyc == k1) || (cyc == k2);
      if (cyc == k1 && w1l > 0) push_window(w1s, w1d, w1l, rst_at >= 0);
      if (cyc == k2 && w2l > 0) push_window(w2s, w2d, w2l, rst_at >= 0);
      if (cyc == 63) chk("rdy_before_fill", rdy, 0);
      if (cyc == 64) chk("rdy_after_fill", rdy, 1);
      if (cyc == busy_low - 1) chk("busy_last", busy, 1);
      if (cyc == busy_low) chk("busy_low", busy, 0);
      if (cyc == last_cyc) begin
        chk("drop_cnt", trig_drop_cnt, exp_drop);
        break;
      end
      @(negedge clk);
    end
  endtask

  // Monitor: pops the scoreboard on every valid output.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
          n_checks++; n_fail++;
          $display("FAIL missing_sample: expected cyc %0d data %0d, got nothing", sb[0].cyc, sb[0].data);
          void'(sb.pop_front());
        end
        if (out_valid) begin
          if (sb.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_valid @cyc %0d: got data %0d, expected no output", cyc, out_data);
          end else begin
            mon_e = sb.pop_front();
            $display("txn cyc=%0d data=%0d first=%0b last=%0b", cyc, out_data, out_first, out_last);
            chk("win_cycle", cyc, mon_e.cyc);
            chk("win_data", out_data, mon_e.data);
            chk("win_first", out_first, mon_e.first);
            chk("win_last", out_last, mon_e.last);
          end
        end else begin
          chk("idle_flags", {out_first, out_last}, 0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    //        name        k1   k2   pre post last rst   w1s  w1d w1l  w2s  w2d w2l busy_low drop
    run_test("fill",      -1,  -1,  4,  3,   70, -1,    0,   0,  0,   0,   0,  0,  -5,     0);
    run_test("basic",     100, -1,  4,  3,  115, -1,  101,  96,  8,   0,   0,  0, 109,     0);
    run_test("clip_lo",   100, -1,  0,  3,  115, -1,  101,  99,  5,   0,   0,  0, 106,     0);
    run_test("clip_hi",   100, -1, 63,  3,  175, -1,  101,  38, 66,   0,   0,  0, 167,     0);
    run_test("b2b",       100, 108, 4,  3,  125, -1,  101,  96,  8, 109, 104,  8, 117,     0);
`ifdef PTB_RETRIGGER_EN
    run_test("retrig",    100, 104, 4,  3,  125, -1,  101,  96, 12,   0,   0,  0, 113,     0);
`else
    run_test("retrig",    100, 104, 4,  3,  125, -1,  101,  96,  8,   0,   0,  0, 109,     1);
`endif
    run_test("abort",     100, -1,  4,  3,  115, 104, 101,  96,  3,   0,   0,  0,  -5,     0);
    run_test("after_rst", 100, -1,  4,  3,  115, -1,  101,  96,  8,   0,   0,  0, 109,     0);
    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
